// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit.
//   NPC_*    : encodings of the npc_op field driven by the NPC unit.
//   ST_*     : FSM state encodings (BOOT, RUN, SLEEP), carried as pc_state_t.
package pc_pkg;

    localparam logic [2:0] NPC_SEQ    = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b011;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_BOOT  = 2'd0;
    localparam pc_state_t ST_RUN   = 2'd1;
    localparam pc_state_t ST_SLEEP = 2'd2;

endpackage

// File: rtl/pc_unit_if.sv
// Bus bundle between the PC unit and its neighbours (NPC unit, hazard unit,
// CSR logic, instruction memory, IF/ID).
//   master : the surrounding pipeline; drives control/targets, observes PC outputs.
//   slave  : the PC unit itself.
// pc_valid is a valid-only qualifier with no ready: when high, the fetch
// address on pc is meaningful for this cycle; there is no back-pressure on
// the fetch side, stall is the only hold mechanism.
// dbg_state / dbg_pend_vld expose internal FSM state and pending-slot
// occupancy for observation.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    import pc_pkg::*;

    logic            stall;
    logic [2:0]      npc_op;
    logic [XLEN-1:0] npc;
    logic            trap;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] mtvec;
    logic            mret;
    logic            wfi;
    logic            irq;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] epc;
    logic            pc_valid;
    logic            misalign;
    logic            halted;
    pc_state_t       dbg_state;
    logic            dbg_pend_vld;

    modport master (
        output stall, npc_op, npc, trap, trap_pc, mtvec, mret, wfi, irq,
        input  pc, pc_plus, epc, pc_valid, misalign, halted, dbg_state, dbg_pend_vld
    );

    modport slave (
        input  stall, npc_op, npc, trap, trap_pc, mtvec, mret, wfi, irq,
        output pc, pc_plus, epc, pc_valid, misalign, halted, dbg_state, dbg_pend_vld
    );

endinterface

// File: rtl/pc_pending_slot.sv
// One-entry buffer holding a redirect target that arrived while the pipeline
// was stalled.
//   clk, rst : falling-edge clock, asynchronous active-high reset
//   load     : capture tgt_in and mark valid (newest load overwrites)
//   clear    : drop the entry; wins over load
//   tgt_in   : target to capture
//   valid    : slot occupied
//   tgt      : stored target
module pc_pending_slot #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] tgt_in,
    output logic            valid,
    output logic [XLEN-1:0] tgt
);

    logic            vld_q, vld_d;
    logic [XLEN-1:0] tgt_q, tgt_d;

    always_comb begin
        vld_d = vld_q;
        tgt_d = tgt_q;
        if (clear) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d = 1'b1;
            tgt_d = tgt_in;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            tgt_q <= '0;
        end else begin
            vld_q <= vld_d;
            tgt_q <= tgt_d;
        end
    end

    assign valid = vld_q;
    assign tgt   = tgt_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with trap/mret redirection, saved EPC,
// a one-entry pending-redirect buffer for redirects arriving under stall,
// misaligned-target rejection and a WFI sleep state.
//   clk : all state updates on the falling edge
//   rst : asynchronous, active-high
//   bus : pc_unit_if slave (control inputs, pc/pc_plus/epc/pc_valid/
//         misalign/halted outputs, debug state)
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSN_BYTES   = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    pc_state_t       state_q, state_d;
    logic            misalign_q, misalign_d;

    logic            pend_load, pend_clear, pend_vld;
    logic [XLEN-1:0] pend_tgt;
    logic [XLEN-1:0] pc_plus;
    logic            redirect, misaligned;

    // Wraps modulo 2^XLEN by construction.
    assign pc_plus    = pc_q + XLEN'(INSN_BYTES);
    assign redirect   = (bus.npc_op != NPC_SEQ);
    assign misaligned = (bus.npc % XLEN'(INSN_BYTES)) != '0;

    pc_pending_slot #(.XLEN(XLEN)) u_pend (
        .clk    (clk),
        .rst    (rst),
        .load   (pend_load),
        .clear  (pend_clear),
        .tgt_in (bus.npc),
        .valid  (pend_vld),
        .tgt    (pend_tgt)
    );

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        state_d    = state_q;
        misalign_d = 1'b0;
        pend_load  = 1'b0;
        pend_clear = 1'b0;

        if (bus.trap) begin
            pc_d       = bus.mtvec;
            epc_d      = bus.trap_pc;
            pend_clear = 1'b1;
            state_d    = ST_RUN;
        end else if (bus.mret) begin
            pc_d       = epc_q;
            pend_clear = 1'b1;
            state_d    = ST_RUN;
        end else begin
            case (state_q)
                // Reset vector is held for one cycle, then fetched in RUN.
                ST_BOOT:  state_d = ST_RUN;
                ST_SLEEP: if (bus.irq) state_d = ST_RUN;
                default: begin
                    state_d = ST_RUN;
                    if (redirect && misaligned) begin
                        // Behaves like a trap; a stale pending target must
                        // not hijack the handler, so the slot is dropped too.
                        pc_d       = bus.mtvec;
                        epc_d      = bus.trap_pc;
                        misalign_d = 1'b1;
                        pend_clear = 1'b1;
                    end else if (bus.stall) begin
                        if (redirect) pend_load = 1'b1;
                    end else if (redirect) begin
                        // A live redirect supersedes anything buffered.
                        pc_d       = bus.npc;
                        pend_clear = 1'b1;
                    end else if (pend_vld) begin
                        pc_d       = pend_tgt;
                        pend_clear = 1'b1;
                    end else if (bus.wfi) begin
                        pc_d    = pc_plus;
                        state_d = ST_SLEEP;
                    end else begin
                        pc_d = pc_plus;
                    end
                end
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            state_q    <= ST_BOOT;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus      = pc_plus;
    assign bus.epc          = epc_q;
    assign bus.pc_valid     = (state_q == ST_RUN);
    assign bus.halted       = (state_q == ST_SLEEP);
    assign bus.misalign     = misalign_q;
    assign bus.dbg_state    = state_q;
    assign bus.dbg_pend_vld = pend_vld;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset/boot, stalled redirect, trap/mret,
// misaligned redirect, WFI sleep/wake, wraparound and async reset.
module tb_pc_unit;
    import pc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .INSN_BYTES   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- scoreboard ----------------
    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.stall   = 1'b0;
        bus.npc_op  = NPC_SEQ;
        bus.npc     = '0;
        bus.trap    = 1'b0;
        bus.trap_pc = '0;
        bus.mtvec   = '0;
        bus.mret    = 1'b0;
        bus.wfi     = 1'b0;
        bus.irq     = 1'b0;
    endtask

    // Advance one active (falling) edge and settle away from it.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_pc_seq(input string tag);
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            check_val(tag, bus.pc, e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        idle_inputs();

        // 1: reset state and boot
        #1;
        check_val("rst_pc",       bus.pc, 32'h0);
        check_val("rst_valid",    32'(bus.pc_valid), 32'h0);
        check_val("rst_halted",   32'(bus.halted), 32'h0);
        check_val("rst_misalign", 32'(bus.misalign), 32'h0);
        check_val("rst_epc",      bus.epc, 32'h0);
        check_val("rst_state",    32'(bus.dbg_state), 32'(ST_BOOT));
        @(posedge clk);
        rst = 1'b0;
        #1;
        check_val("boot_valid", 32'(bus.pc_valid), 32'h0);
        step();
        check_val("run0_pc",    bus.pc, 32'h0);
        check_val("run0_valid", 32'(bus.pc_valid), 32'h1);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        check_pc_seq("seq_pc");
        check_val("seq_pc_plus", bus.pc_plus, 32'hC);

        // 2: redirect under stall is buffered, applied on first unstalled edge
        bus.stall  = 1'b1;
        bus.npc_op = NPC_BRANCH;
        bus.npc    = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_pc_hold", bus.pc, 32'h8);
            check_val("stall_pend",    32'(bus.dbg_pend_vld), 32'h1);
        end
        bus.stall  = 1'b0;
        bus.npc_op = NPC_SEQ;
        step();
        check_val("pend_apply_pc", bus.pc, 32'h100);
        check_val("pend_cleared",  32'(bus.dbg_pend_vld), 32'h0);
        step();
        check_val("pend_next_pc",  bus.pc, 32'h104);

        // 3: trap overrides stall, mret returns to epc
        bus.trap    = 1'b1;
        bus.stall   = 1'b1;
        bus.trap_pc = 32'h20;
        bus.mtvec   = 32'h80;
        step();
        check_val("trap_pc",  bus.pc, 32'h80);
        check_val("trap_epc", bus.epc, 32'h20);
        bus.trap  = 1'b0;
        bus.stall = 1'b0;
        step();
        check_val("handler_pc", bus.pc, 32'h84);
        bus.mret = 1'b1;
        step();
        check_val("mret_pc", bus.pc, 32'h20);
        bus.mret = 1'b0;

        // 4: misaligned jalr target traps and pulses misalign once
        bus.npc_op  = NPC_JALR;
        bus.npc     = 32'h102;
        bus.trap_pc = 32'h30;
        step();
        check_val("mis_pc",    bus.pc, 32'h80);
        check_val("mis_epc",   bus.epc, 32'h30);
        check_val("mis_pulse", 32'(bus.misalign), 32'h1);
        bus.npc_op = NPC_SEQ;
        step();
        check_val("mis_after_pc",    bus.pc, 32'h84);
        check_val("mis_pulse_clear", 32'(bus.misalign), 32'h0);

        // 5: wfi sleeps at resume address, ignores redirects/stall, irq wakes
        bus.npc_op = NPC_JAL;
        bus.npc    = 32'h40;
        step();
        check_val("jal_pc", bus.pc, 32'h40);
        bus.npc_op = NPC_SEQ;
        bus.wfi    = 1'b1;
        step();
        check_val("wfi_pc",     bus.pc, 32'h44);
        check_val("wfi_halted", 32'(bus.halted), 32'h1);
        check_val("wfi_valid",  32'(bus.pc_valid), 32'h0);
        bus.wfi = 1'b0;
        bus.npc = 32'h200;
        for (int i = 0; i < 5; i++) begin
            bus.npc_op = (i % 2 == 0) ? NPC_BRANCH : NPC_SEQ;
            bus.stall  = (i == 2);
            step();
            check_val("sleep_pc_hold", bus.pc, 32'h44);
            check_val("sleep_halted",  32'(bus.halted), 32'h1);
        end
        bus.npc_op = NPC_SEQ;
        bus.stall  = 1'b0;
        bus.irq    = 1'b1;
        step();
        check_val("wake_pc",     bus.pc, 32'h44);
        check_val("wake_halted", 32'(bus.halted), 32'h0);
        check_val("wake_valid",  32'(bus.pc_valid), 32'h1);
        bus.irq = 1'b0;
        step();
        check_val("wake_next_pc", bus.pc, 32'h48);

        // 6: wraparound, then async reset mid-stream with a pending entry
        bus.npc_op = NPC_BRANCH;
        bus.npc    = 32'hFFFF_FFFC;
        step();
        check_val("top_pc",      bus.pc, 32'hFFFF_FFFC);
        check_val("top_pc_plus", bus.pc_plus, 32'h0);
        bus.npc_op = NPC_SEQ;
        step();
        check_val("wrap_pc", bus.pc, 32'h0);
        step();
        check_val("wrap_next_pc", bus.pc, 32'h4);
        bus.stall  = 1'b1;
        bus.npc_op = NPC_BRANCH;
        bus.npc    = 32'h300;
        step();
        check_val("pre_rst_pend", 32'(bus.dbg_pend_vld), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_pc",    bus.pc, 32'h0);
        check_val("arst_pend",  32'(bus.dbg_pend_vld), 32'h0);
        check_val("arst_epc",   bus.epc, 32'h0);
        check_val("arst_valid", 32'(bus.pc_valid), 32'h0);
        check_val("arst_state", 32'(bus.dbg_state), 32'(ST_BOOT));
        idle_inputs();
        #1;
        rst = 1'b0;
        step();
        check_val("reboot_pc",    bus.pc, 32'h0);
        check_val("reboot_valid", 32'(bus.pc_valid), 32'h1);
        step();
        check_val("reboot_next_pc", bus.pc, 32'h4);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
